store_checker: RTL
==================

# store_checker

Parametrised, self-checking store monitor for the pipelined RISC-V core's data-memory write port. It sits beside `top` in simulation and, optionally, on FPGA, and observes MemWrite/DataAdr/WriteData/MemWriteSelect. It compares each store, in order, against a programmed list of expected stores, and ends in a sticky PASS or FAIL verdict with a cause code, covering the single hard-coded pass/fail check the bench used to do by hand.

## Interface
- `NUM_EXP`, 8: depth of the expected-store list.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; must be a multiple of 8.
- `TIMEOUT`, 1000: maximum RUN cycles before a timeout failure; must be ≥1.
- `IGN_BASE`, 96: base address of the ignore window.
- `IGN_SIZE`, 4: size of the ignore window in bytes; 0 disables the window.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `MemWrite` in 1: store strobe from the core.
- `DataAdr` in ADDR_W: store address.
- `WriteData` in DATA_W: store data.
- `MemWriteSelect` in DATA_W/8: byte enables.
- `exp_we` in 1: append one expected entry; honoured in IDLE only.
- `exp_addr` in ADDR_W: expected address.
- `exp_data` in DATA_W: expected data.
- `exp_mask` in DATA_W/8: expected byte enables.
- `start` in 1: IDLE→RUN.
- `clr` in 1: synchronous return to IDLE; clears the list, counters and verdict.
- `busy` out 1: high in RUN.
- `done` out 1: high in PASS or FAIL.
- `pass` out 1: high in PASS.
- `fail` out 1: high in FAIL.
- `fail_code` out 2: 0 none, 1 unexpected address, 2 data/mask mismatch, 3 timeout.
- `fail_idx` out $clog2(NUM_EXP)+1: list pointer at the time of failure.
- `match_cnt` out $clog2(NUM_EXP)+1: number of stores matched so far.
- `cycle_cnt` out $clog2(TIMEOUT)+1: number of RUN cycles elapsed.
- `exp_cnt` out $clog2(NUM_EXP)+1: number of entries loaded.
- `overflow` out 1: an append was dropped because the list was full; sticky.

## Operation
- **States and transitions**
  - IDLE, RUN, PASS, FAIL.
  - IDLE→RUN on `start`.
  - RUN→PASS or RUN→FAIL per the rules below.
  - PASS and FAIL are sticky; only `clr` or `reset` leaves them.
  - `clr` has priority over every other input in every state.
- **Loading (IDLE only)**
  - `exp_we` writes {addr, data, mask} to slot `exp_cnt`, then increments `exp_cnt`.
  - When `exp_cnt == NUM_EXP`, the write is dropped and `overflow` is set.
  - `exp_we` outside IDLE is ignored.
- **Checking in RUN**
  - A store is checked on any cycle with `MemWrite=1`.
  - Let E = entry[match_cnt] and M = `MemWriteSelect` expanded to byte lanes.
  - Match: `DataAdr==E.addr`, `MemWriteSelect==E.mask`, and `(WriteData&M)==(E.data&M)`. On a match, `match_cnt` increments.
  - `DataAdr==E.addr` but the data or mask differs → FAIL, code 2.
  - Address differs and IGN_BASE ≤ `DataAdr` < IGN_BASE+IGN_SIZE → the store is ignored.
  - Address differs and the store is outside the window → FAIL, code 1.
  - On entry to FAIL, `fail_idx` = `match_cnt`, and `match_cnt` is frozen.
- **Completion**
  - `match_cnt == exp_cnt` → PASS.
  - `start` with `exp_cnt == 0` → RUN for one cycle, then PASS.
- **Timeout**
  - `cycle_cnt` increments each RUN cycle.
  - On the edge where it would reach TIMEOUT without completion → FAIL, code 3.
- **Simultaneous events**
  - A final match and a timeout on the same edge → PASS.
  - A mismatch and a timeout on the same edge → code 1 or 2, whichever applies; the mismatch takes priority.
- **Reset**
  - `reset` mid-operation forces IDLE immediately (asynchronous).
  - It clears every counter, flag and the verdict.
  - List contents need not be cleared; `exp_cnt=0` invalidates them.

## Timing
- **Reset values:** `busy`, `done`, `pass`, `fail`, `overflow` = 0; `fail_code`, `fail_idx`, `match_cnt`, `cycle_cnt`, `exp_cnt` = 0.
- **Start:** `start` sampled at edge N → `busy`=1 after edge N. A store present in the same cycle as `start` is not checked.
- **Store latency:** a store sampled at edge N is reflected in `match_cnt`, `pass` or `fail` after edge N (1-cycle latency). Outputs are registered.
- **Append:** `exp_we` at edge N → `exp_cnt` updated after edge N.
- **Timeout:** with TIMEOUT=T, `fail` rises after the T-th RUN edge, with `cycle_cnt` = T.

## Structure
- Shared package `store_checker_pkg` holds:
  - the state enum (IDLE/RUN/PASS/FAIL);
  - the fail-code enum (NONE/BAD_ADDR/BAD_DATA/TIMEOUT);
  - a `mask_expand` function that turns byte enables into a DATA_W lane mask.
- One sub-module, `store_exp_mem`, holds the NUM_EXP × (ADDR_W+DATA_W+DATA_W/8) list. It has:
  - a write port (append);
  - a combinational read port indexed by `match_cnt`.
- The FSM, counters and compare logic live in `store_checker`.

## Test plan
- **Basic pass through the ignore window:** load (100, 25, 4'hF); `start`; stores 96/7 then 100/25 → `pass`=1 one cycle after the second store, `match_cnt`=1, `fail`=0.
- **Unexpected address:** same list; store 104/25 → `fail`=1, `fail_code`=1, `fail_idx`=0.
- **Data mismatch:** same list; store 100/26 → `fail_code`=2. Then store 100/25 → remains FAIL (sticky).
- **Byte lanes:** load (100, 32'h0000_00AB, 4'b0001); store `WriteData`=32'hFFFF_FFAB with `MemWriteSelect`=4'b0001 → PASS. Repeating with `MemWriteSelect`=4'b0011 → `fail_code`=2.
- **Timeout:** TIMEOUT=20; load one entry; `start`; no stores → `fail`=1, `fail_code`=3, `cycle_cnt`=20 after the 20th RUN edge.
- **Overflow, then reset mid-run:** NUM_EXP+1 appends → `exp_cnt`=NUM_EXP, `overflow`=1. Then `start`, and assert `reset` mid-RUN between edges → all outputs 0 immediately.

Source files
------------

// File: rtl/store_checker_pkg.sv
// Shared types and helpers for the store checker.
package store_checker_pkg;

  // Widest data bus the lane-mask helper supports.
  localparam int MAX_DATA_W = 256;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_BAD_ADDR = 2'd1,
    FC_BAD_DATA = 2'd2,
    FC_TIMEOUT  = 2'd3
  } fail_code_e;

  // Expand byte enables into a per-bit lane mask.
  function automatic logic [MAX_DATA_W-1:0] mask_expand(input logic [MAX_BE_W-1:0] be);
    logic [MAX_DATA_W-1:0] m;
    for (int i = 0; i < MAX_BE_W; i++) begin
      m[i*8 +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/store_exp_mem.sv
// Expected-store list: append write port, combinational read port.
module store_exp_mem
  import store_checker_pkg::*;
#(
  parameter int NUM_EXP = 8,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 3
) (
  input  logic                clk,
  input  logic                i_wr_en,
  input  logic [IDX_W-1:0]    i_wr_idx,
  input  logic [ADDR_W-1:0]   i_wr_addr,
  input  logic [DATA_W-1:0]   i_wr_data,
  input  logic [DATA_W/8-1:0] i_wr_mask,
  input  logic [IDX_W-1:0]    i_rd_idx,
  output logic [ADDR_W-1:0]   o_rd_addr,
  output logic [DATA_W-1:0]   o_rd_data,
  output logic [DATA_W/8-1:0] o_rd_mask
);

  logic [ADDR_W-1:0]   r_addr [NUM_EXP];
  logic [DATA_W-1:0]   r_data [NUM_EXP];
  logic [DATA_W/8-1:0] r_mask [NUM_EXP];

  // Storage only; validity is tracked by the entry count in the checker.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_addr[i_wr_idx] <= i_wr_addr;
      r_data[i_wr_idx] <= i_wr_data;
      r_mask[i_wr_idx] <= i_wr_mask;
    end
  end

  assign o_rd_addr = r_addr[i_rd_idx];
  assign o_rd_data = r_data[i_rd_idx];
  assign o_rd_mask = r_mask[i_rd_idx];

endmodule

// File: rtl/store_checker.sv
// In-order store monitor: compares observed stores against a loaded list.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | loading expected entries, waiting for start
// ST_RUN  | checking stores in order, counting cycles toward timeout
// ST_PASS | every expected store matched (sticky)
// ST_FAIL | bad address, bad data/mask or timeout (sticky)
module store_checker
  import store_checker_pkg::*;
#(
  parameter int          NUM_EXP  = 8,
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int          TIMEOUT  = 1000,
  parameter int unsigned IGN_BASE = 96,
  parameter int unsigned IGN_SIZE = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       MemWrite,
  input  logic [ADDR_W-1:0]          DataAdr,
  input  logic [DATA_W-1:0]          WriteData,
  input  logic [DATA_W/8-1:0]        MemWriteSelect,
  input  logic                       exp_we,
  input  logic [ADDR_W-1:0]          exp_addr,
  input  logic [DATA_W-1:0]          exp_data,
  input  logic [DATA_W/8-1:0]        exp_mask,
  input  logic                       start,
  input  logic                       clr,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic [1:0]                 fail_code,
  output logic [$clog2(NUM_EXP):0]   fail_idx,
  output logic [$clog2(NUM_EXP):0]   match_cnt,
  output logic [$clog2(TIMEOUT):0]   cycle_cnt,
  output logic [$clog2(NUM_EXP):0]   exp_cnt,
  output logic                       overflow
);

  localparam int CNT_W = $clog2(NUM_EXP) + 1;
  localparam int CYC_W = $clog2(TIMEOUT) + 1;
  localparam int IDX_W = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1;
  localparam int BE_W  = DATA_W / 8;

  localparam logic [CNT_W-1:0]  FULL   = CNT_W'(NUM_EXP);
  // Terminal count: the RUN edge leaving the counter at TIMEOUT.
  localparam logic [CYC_W-1:0]  TC     = CYC_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]   IGN_LO = (ADDR_W+1)'(longint'(IGN_BASE));
  localparam logic [ADDR_W:0]   IGN_HI = (ADDR_W+1)'(longint'(IGN_BASE) + longint'(IGN_SIZE));

  state_e           r_state, w_state_nxt;
  fail_code_e       r_fail_code, w_fail_code_nxt;
  logic [CNT_W-1:0] r_match_cnt, w_match_cnt_nxt;
  logic [CNT_W-1:0] r_exp_cnt, w_exp_cnt_nxt;
  logic [CNT_W-1:0] r_fail_idx, w_fail_idx_nxt;
  logic [CYC_W-1:0] r_cycle_cnt, w_cycle_cnt_nxt;
  logic             r_overflow, w_overflow_nxt;
  logic             r_busy, r_done, r_pass, r_fail;

  logic                  w_wr_en;
  logic [ADDR_W-1:0]     w_e_addr;
  logic [DATA_W-1:0]     w_e_data;
  logic [BE_W-1:0]       w_e_mask;
  logic [MAX_DATA_W-1:0] w_lane;
  logic                  w_addr_eq, w_mask_eq, w_data_eq, w_in_win;

  store_exp_mem #(
    .NUM_EXP (NUM_EXP),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .IDX_W   (IDX_W)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (r_exp_cnt[IDX_W-1:0]),
    .i_wr_addr (exp_addr),
    .i_wr_data (exp_data),
    .i_wr_mask (exp_mask),
    .i_rd_idx  (r_match_cnt[IDX_W-1:0]),
    .o_rd_addr (w_e_addr),
    .o_rd_data (w_e_data),
    .o_rd_mask (w_e_mask)
  );

  // Data is compared only on lanes the core actually writes.
  assign w_lane    = mask_expand(MAX_BE_W'(MemWriteSelect));
  assign w_addr_eq = (DataAdr == w_e_addr);
  assign w_mask_eq = (MemWriteSelect == w_e_mask);
  assign w_data_eq = ((MAX_DATA_W'(WriteData) & w_lane) == (MAX_DATA_W'(w_e_data) & w_lane));
  assign w_in_win  = (IGN_SIZE != 0) && ({1'b0, DataAdr} >= IGN_LO) && ({1'b0, DataAdr} < IGN_HI);

  // Next-state, counter and verdict logic; clr overrides everything.
  always_comb begin
    w_state_nxt     = r_state;
    w_fail_code_nxt = r_fail_code;
    w_match_cnt_nxt = r_match_cnt;
    w_exp_cnt_nxt   = r_exp_cnt;
    w_fail_idx_nxt  = r_fail_idx;
    w_cycle_cnt_nxt = r_cycle_cnt;
    w_overflow_nxt  = r_overflow;
    w_wr_en         = 1'b0;
    if (clr) begin
      w_state_nxt     = ST_IDLE;
      w_fail_code_nxt = FC_NONE;
      w_match_cnt_nxt = '0;
      w_exp_cnt_nxt   = '0;
      w_fail_idx_nxt  = '0;
      w_cycle_cnt_nxt = '0;
      w_overflow_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (exp_we) begin
            if (r_exp_cnt == FULL) begin
              w_overflow_nxt = 1'b1;
            end else begin
              w_wr_en       = 1'b1;
              w_exp_cnt_nxt = r_exp_cnt + CNT_W'(1);
            end
          end
          if (start) w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          w_cycle_cnt_nxt = r_cycle_cnt + CYC_W'(1);
          if (r_match_cnt == r_exp_cnt) begin
            // Empty list completes without looking at stores.
            w_state_nxt = ST_PASS;
          end else if (MemWrite && w_addr_eq && !(w_mask_eq && w_data_eq)) begin
            w_state_nxt     = ST_FAIL;
            w_fail_code_nxt = FC_BAD_DATA;
            w_fail_idx_nxt  = r_match_cnt;
          end else if (MemWrite && !w_addr_eq && !w_in_win) begin
            w_state_nxt     = ST_FAIL;
            w_fail_code_nxt = FC_BAD_ADDR;
            w_fail_idx_nxt  = r_match_cnt;
          end else begin
            if (MemWrite && w_addr_eq) w_match_cnt_nxt = r_match_cnt + CNT_W'(1);
            // Completion beats a timeout landing on the same edge.
            if (w_match_cnt_nxt == r_exp_cnt) begin
              w_state_nxt = ST_PASS;
            end else if (r_cycle_cnt == TC) begin
              w_state_nxt     = ST_FAIL;
              w_fail_code_nxt = FC_TIMEOUT;
              w_fail_idx_nxt  = w_match_cnt_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_fail_code <= FC_NONE;
      r_match_cnt <= '0;
      r_exp_cnt   <= '0;
      r_fail_idx  <= '0;
      r_cycle_cnt <= '0;
      r_overflow  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_fail_code <= w_fail_code_nxt;
      r_match_cnt <= w_match_cnt_nxt;
      r_exp_cnt   <= w_exp_cnt_nxt;
      r_fail_idx  <= w_fail_idx_nxt;
      r_cycle_cnt <= w_cycle_cnt_nxt;
      r_overflow  <= w_overflow_nxt;
      r_busy      <= (w_state_nxt == ST_RUN);
      r_done      <= (w_state_nxt == ST_PASS) || (w_state_nxt == ST_FAIL);
      r_pass      <= (w_state_nxt == ST_PASS);
      r_fail      <= (w_state_nxt == ST_FAIL);
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail      = r_fail;
  assign fail_code = r_fail_code;
  assign fail_idx  = r_fail_idx;
  assign match_cnt = r_match_cnt;
  assign cycle_cnt = r_cycle_cnt;
  assign exp_cnt   = r_exp_cnt;
  assign overflow  = r_overflow;

endmodule
